// File: rtl/descrypt_crypt_ctrl.sv
// rtl/descrypt_crypt_ctrl.sv - batch sequencer for the 16-stage descrypt round pipeline
module descrypt_crypt_ctrl #(
  parameter int N_STAGES = 16,
  parameter int N_ITER   = 25,
  parameter int SALT_W   = 12
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [55:0]       in_key,
  input  logic [SALT_W-1:0] in_salt,
  input  logic              in_last,
  output logic              rnd_enable,
  output logic              rnd_start,
  output logic [55:0]       rnd_CiDi,
  output logic              rnd_valid,
  output logic [SALT_W-1:0] rnd_salt,
  input  logic [55:0]       pipe_CiDi,
  input  logic [63:0]       pipe_T,
  input  logic              pipe_valid,
  output logic              out_valid,
  output logic [63:0]       out_T,
  output logic [3:0]        out_slot,
  output logic              busy
);

  localparam int IW = (N_ITER > 2) ? $clog2(N_ITER) : 1;
  localparam logic [3:0]    SLOT_LAST  = 4'(N_STAGES - 1);
  localparam logic [IW-1:0] ITER_LAST  = IW'(N_ITER - 1);
  localparam logic [4:0]    DRAIN_FULL = 5'(N_STAGES);

  typedef enum logic [1:0] {IDLE, LOAD, CRYPT} state_t;

  state_t            state;
  logic [3:0]        slot;
  logic [IW-1:0]     iter;
  logic [4:0]        drain;
  logic [SALT_W-1:0] salt_q;
  logic              closed;   // in_last already taken this batch
  logic              accept;
  logic              accept_idle;
  logic              draining;

  assign draining = (drain != 5'd0);

  // A new batch may start only once the old salt is no longer needed by any round
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = !draining || (in_salt == salt_q);
      LOAD:    in_ready = !closed;
      default: in_ready = 1'b0;
    endcase
    if (!RESET_N) in_ready = 1'b0;
  end

  assign accept      = in_valid && in_ready;
  assign accept_idle = accept && (state == IDLE);

  assign rnd_start  = accept_idle || (state == LOAD);
  assign rnd_CiDi   = (state == CRYPT) ? pipe_CiDi : in_key;
  assign rnd_valid  = (state == CRYPT) ? pipe_valid : accept;
  assign rnd_enable = (state != IDLE) || draining || accept_idle;
  assign rnd_salt   = accept_idle ? in_salt : salt_q;

  assign out_valid = draining && pipe_valid;
  assign out_T     = pipe_T;
  assign out_slot  = 4'(DRAIN_FULL - drain);
  assign busy      = (state != IDLE) || draining;

  // Sequencer state, slot/iteration counters, drain counter and salt register
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state  <= IDLE;
      slot   <= 4'd0;
      iter   <= '0;
      drain  <= 5'd0;
      salt_q <= '0;
      closed <= 1'b0;
    end else begin
      if (draining) drain <= drain - 5'd1;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= LOAD;
            slot   <= 4'd1;
            iter   <= '0;
            salt_q <= in_salt;
            closed <= in_last;
          end
        end
        LOAD: begin
          if (accept && in_last) closed <= 1'b1;
          if (slot == SLOT_LAST) begin
            state <= CRYPT;
            slot  <= 4'd0;
            iter  <= IW'(1);
          end else begin
            slot <= slot + 4'd1;
          end
        end
        CRYPT: begin
          if (slot == SLOT_LAST) begin
            slot <= 4'd0;
            if (iter == ITER_LAST) begin
              state <= IDLE;
              drain <= DRAIN_FULL;
            end else begin
              iter <= iter + IW'(1);
            end
          end else begin
            slot <= slot + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_descrypt_crypt_ctrl.sv
// tb/tb_descrypt_crypt_ctrl.sv - scoreboard bench with a 16-stage round pipeline model
module tb_descrypt_crypt_ctrl;

  localparam int NS = 16;
  localparam int NI = 25;
  localparam int LAT = NS * NI;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] in_key;
  logic [11:0] in_salt;
  logic        in_last;
  logic        rnd_enable, rnd_start, rnd_valid;
  logic [55:0] rnd_CiDi;
  logic [11:0] rnd_salt;
  logic [55:0] pipe_CiDi;
  logic [63:0] pipe_T;
  logic        pipe_valid;
  logic        out_valid;
  logic [63:0] out_T;
  logic [3:0]  out_slot;
  logic        busy;

  descrypt_crypt_ctrl #(.N_STAGES(NS), .N_ITER(NI), .SALT_W(12)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_salt(in_salt), .in_last(in_last),
    .rnd_enable(rnd_enable), .rnd_start(rnd_start), .rnd_CiDi(rnd_CiDi), .rnd_valid(rnd_valid),
    .rnd_salt(rnd_salt),
    .pipe_CiDi(pipe_CiDi), .pipe_T(pipe_T), .pipe_valid(pipe_valid),
    .out_valid(out_valid), .out_T(out_T), .out_slot(out_slot), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stand-in round function and key schedule step
  function automatic logic [55:0] rot_cd(input logic [55:0] c);
    return {c[54:28], c[55], c[26:0], c[27]};
  endfunction

  function automatic logic [63:0] round_t(input logic [55:0] c, input logic [63:0] t,
                                          input logic [11:0] s, input int r);
    return {t[62:0], t[63]} ^ {8'h00, c} ^ {52'h0, s} ^ (64'(r + 1) << 40);
  endfunction

  function automatic logic [63:0] sw_crypt(input logic [55:0] key, input logic [11:0] s);
    logic [55:0] c = key;
    logic [63:0] t = 64'h0;
    for (int p = 0; p < NI; p++)
      for (int r = 0; r < NS; r++) begin
        t = round_t(c, t, s, r);
        c = rot_cd(c);
      end
    return t;
  endfunction

  // Round pipeline: round 0 freezable and clearable, rounds 1..15 free-running
  logic [55:0] pc [NS];
  logic [63:0] pt [NS];
  logic        pv [NS];
  assign pipe_CiDi  = pc[NS-1];
  assign pipe_T     = pt[NS-1];
  assign pipe_valid = pv[NS-1];

  always @(posedge CLK) begin
    if (rnd_enable) begin
      pc[0] <= rot_cd(rnd_CiDi);
      pt[0] <= round_t(rnd_CiDi, rnd_start ? 64'h0 : pipe_T, rnd_salt, 0);
      pv[0] <= rnd_valid;
    end else begin
      pv[0] <= 1'b0;
    end
    for (int i = 1; i < NS; i++) begin
      pc[i] <= rot_cd(pc[i-1]);
      pt[i] <= round_t(pc[i-1], pt[i-1], rnd_salt, i);
      pv[i] <= pv[i-1];
    end
  end

  typedef struct {
    int          due;
    int          slot;
    logic [63:0] t;
  } exp_t;
  exp_t sb[$];

  // Output monitor: every out_valid pulse must match the oldest expectation
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      check_eq("out_missing", 64'(cyc), 64'(sb[0].due));
      void'(sb.pop_front());
    end
    if (RESET_N && out_valid) begin
      if (sb.size() == 0) begin
        check_eq("out_spurious", {60'h0, out_slot}, 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("out_cycle", 64'(cyc), 64'(e.due));
        check_eq("out_slot", {60'h0, out_slot}, 64'(e.slot));
        check_eq("out_T", out_T, e.t);
      end
    end
  end

  // One batch: slot 0 waits for in_ready, then slots 1..15 follow the valid mask
  task automatic run_batch(input logic [11:0] salt, input logic [15:0] vmask,
                           input int last_slot, output int t0);
    bit got = 0;
    t0 = -1;
    in_salt  = salt;
    in_valid = 1'b1;
    in_key   = {24'($urandom), 32'($urandom)};
    in_last  = (last_slot == 0);
    for (int w = 0; w < 2000 && !got; w++) begin
      @(negedge CLK);
      if (in_ready) begin
        got = 1;
        t0 = cyc;
        sb.push_back('{cyc + LAT, 0, sw_crypt(in_key, salt)});
      end
      @(posedge CLK); #1;
    end
    if (!got) begin
      check_eq("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    for (int s = 1; s < NS; s++) begin
      in_valid = vmask[s] && (s <= last_slot);
      in_key   = {24'($urandom), 32'($urandom)};
      in_last  = (s == last_slot);
      @(negedge CLK);
      check_eq($sformatf("ready_slot%0d", s), {63'h0, in_ready}, {63'h0, (s <= last_slot)});
      if (in_valid && in_ready)
        sb.push_back('{cyc + LAT, s, sw_crypt(in_key, salt)});
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drained();
    for (int w = 0; w < 1500 && (sb.size() != 0 || busy); w++) @(posedge CLK);
    #1;
    check_eq("drained", {63'h0, busy}, 64'd0);
  endtask

  int ta, tb, tc, td;

  initial begin
    RESET_N  = 1'b0;
    in_valid = 1'b1;
    in_key   = 56'h0;
    in_salt  = 12'h0;
    in_last  = 1'b0;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_in_ready", {63'h0, in_ready}, 64'd0);
    check_eq("rst_rnd_enable", {63'h0, rnd_enable}, 64'd0);
    in_valid = 1'b0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(negedge CLK);
    check_eq("rst_busy", {63'h0, busy}, 64'd0);
    check_eq("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check_eq("rst_rnd_start", {63'h0, rnd_start}, 64'd0);
    check_eq("rst_rnd_valid", {63'h0, rnd_valid}, 64'd0);

    // Idle for 100 cycles
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      check_eq("idle_quiet", {61'h0, rnd_enable, busy, out_valid}, 64'd0);
    end
    @(posedge CLK); #1;

    // Full batch, then same-salt batch queued behind it
    run_batch(12'h5A5, 16'hFFFF, 15, ta);
    run_batch(12'h5A5, 16'hFFFF, 15, tb);
    check_eq("same_salt_accept", 64'(tb), 64'(ta + LAT));

    // Different salt, short batch: waits for the drain to finish
    run_batch(12'h3C1, 16'hFFFF, 2, tc);
    check_eq("diff_salt_accept", 64'(tc), 64'(tb + LAT + NS));

    // Gaps at slots 4 and 9
    run_batch(12'h3C1, 16'hFDEF, 15, td);
    wait_drained();

    // Reset mid-CRYPT abandons the batch
    run_batch(12'h0F0, 16'hFFFF, 15, ta);
    while (cyc < ta + 200) @(posedge CLK);
    #1;
    RESET_N = 1'b0;
    sb.delete();
    @(negedge CLK);
    check_eq("midrst_in_ready", {63'h0, in_ready}, 64'd0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(negedge CLK);
    check_eq("midrst_busy", {63'h0, busy}, 64'd0);
    check_eq("midrst_rnd_enable", {63'h0, rnd_enable}, 64'd0);
    @(posedge CLK); #1;
    run_batch(12'h777, 16'hFFFF, 15, tb);
    wait_drained();

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
